// File: rtl/div_sequencer.sv
// Multi-cycle restoring integer divider for the execute stage.
// Produces {remainder, quotient} for the HI/LO write path and stalls the pipe while busy.
module div_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      annul_i,
  input  logic                      signed_div_i,
  input  logic [DATA_WIDTH-1:0]     opdata1_i,
  input  logic [DATA_WIDTH-1:0]     opdata2_i,
  output logic [2*DATA_WIDTH-1:0]   result_o,
  output logic                      ready_o,
  output logic                      stall_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nx;
  logic [2*W-1:0]     wr;
  logic [2*W-1:0]     wr_nx;
  logic [W-1:0]       dvs;
  logic [W-1:0]       dvs_nx;
  logic               sgn;
  logic               sgn_nx;
  logic               neg1;
  logic               neg1_nx;
  logic               neg2;
  logic               neg2_nx;
  logic [2*W-1:0]     result_nx;
  logic               ready_nx;

  logic               accept;
  logic               div_zero;
  logic [W-1:0]       mag1;
  logic [W-1:0]       mag2;
  logic [W:0]         upper;
  logic               ge;
  logic [W-1:0]       rem_step;
  logic [2*W-1:0]     wr_step;
  logic               last;
  logic [W-1:0]       quo_fix;
  logic [W-1:0]       rem_fix;

  assign stall_o = start_i & ~ready_o;

  // Operand magnitudes, taken only when a divide is accepted from IDLE
  assign accept   = start_i & ~annul_i;
  assign div_zero = (opdata2_i == '0);
  assign mag1     = (signed_div_i && opdata1_i[W-1]) ? (~opdata1_i + W'(1)) : opdata1_i;
  assign mag2     = (signed_div_i && opdata2_i[W-1]) ? (~opdata2_i + W'(1)) : opdata2_i;

  // One restoring step: {rem, quo} << 1, trial-subtract the divisor from the top W+1 bits
  assign upper    = wr[2*W-1:W-1];
  assign ge       = (upper >= {1'b0, dvs});
  assign rem_step = ge ? W'(upper - {1'b0, dvs}) : upper[W-1:0];
  assign wr_step  = {rem_step, wr[W-2:0], ge};
  assign last     = (cnt == CW'(W));

  // Sign correction: quotient follows operand-sign XOR, remainder follows the dividend
  assign quo_fix  = (sgn && (neg1 ^ neg2)) ? (~wr[W-1:0] + W'(1)) : wr[W-1:0];
  assign rem_fix  = (sgn && neg1) ? (~wr[2*W-1:W] + W'(1)) : wr[2*W-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = div_zero ? BYZERO : RUN;
        end
      end
      BYZERO: state_nx = annul_i ? IDLE : DONE;
      RUN: begin
        if (annul_i) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!start_i || annul_i) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx    = cnt;
    wr_nx     = wr;
    dvs_nx    = dvs;
    sgn_nx    = sgn;
    neg1_nx   = neg1;
    neg2_nx   = neg2;
    result_nx = result_o;
    ready_nx  = ready_o;
    case (state)
      IDLE: begin
        cnt_nx    = '0;
        result_nx = '0;
        ready_nx  = 1'b0;
        if (accept) begin
          sgn_nx  = signed_div_i;
          neg1_nx = signed_div_i & opdata1_i[W-1];
          neg2_nx = signed_div_i & opdata2_i[W-1];
          if (!div_zero) begin
            wr_nx  = {{W{1'b0}}, mag1};
            dvs_nx = mag2;
          end
        end
      end
      BYZERO: begin
        result_nx = '0;
        ready_nx  = ~annul_i;
        cnt_nx    = '0;
      end
      RUN: begin
        if (annul_i) begin
          cnt_nx    = '0;
          result_nx = '0;
          ready_nx  = 1'b0;
        end else if (!last) begin
          wr_nx  = wr_step;
          cnt_nx = cnt + CW'(1);
        end else begin
          result_nx = {rem_fix, quo_fix};
          ready_nx  = 1'b1;
        end
      end
      DONE: begin
        if (!start_i || annul_i) begin
          result_nx = '0;
          ready_nx  = 1'b0;
        end
      end
      default: begin
        result_nx = '0;
        ready_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wr       <= '0;
      dvs      <= '0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      wr       <= wr_nx;
      dvs      <= dvs_nx;
      sgn      <= sgn_nx;
      neg1     <= neg1_nx;
      neg2     <= neg2_nx;
      result_o <= result_nx;
      ready_o  <= ready_nx;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_o      (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: start, wait for ready, hold in DONE, drop start, check return to IDLE
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg, input int hold);
    logic [63:0] exp;
    int          edges;
    int          lat;
    exp          = model(a, b, sg);
    lat          = (b == 32'd0) ? 1 : 33;
    start_i      = 1'b1;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    #1;
    check("stall_at_start", 64'(stall_o), 64'd1);
    tick();
    edges = 0;
    while (!ready_o && edges < 100) begin
      if (edges == 2) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sg;
      end
      tick();
      edges++;
    end
    check("latency", 64'(edges), 64'(lat));
    check("result", result_o, exp);
    check("stall_on_ready", 64'(stall_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = $urandom_range(0, 1);
      tick();
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    tick();
    check("drop_ready", 64'(ready_o), 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'(($urandom_range(0, 40)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rises;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    tick();
    tick();
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stall_o), 64'd0);
    rst = 1'b0;
    tick();

    run_div(32'd100, 32'd7, 1'b0, 0);
    check("t1_model", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_div(32'd55, 32'd0, 1'b1, 0);
    run_div(32'hFFFF_FFF9, 32'd0, 1'b0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);

    // Annul at E10: no result, next divide runs at full latency
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    tick();
    rises = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (ready_o) rises++;
    end
    start_i = 1'b0;
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul_no_ready", 64'(rises), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 0);

    // Reset at E15 of a running divide
    start_i      = 1'b1;
    signed_div_i = 1'b1;
    opdata1_i    = 32'd12345;
    opdata2_i    = 32'd17;
    tick();
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_stall", 64'(stall_o), 64'd0);
    run_div(32'd12345, 32'd17, 1'b1, 0);

    run_div(32'hDEAD_BEEF, 32'd1234, 1'b1, 5);

    for (int n = 0; n < 30; n++) begin
      run_div(pick(), pick(), 1'(($urandom_range(0, 1))), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle integer divide controller for the execute stage.
- Takes operands and the divide op from the EX decode of aluop.
- Sequences a shared shift/subtract datapath over DATA_WIDTH iterations.
- Stalls the pipeline while busy.
- Returns quotient/remainder as a {HI,LO} pair for the HI/LO write path.

Parameters:
DATA_WIDTH, 32, operand width; also the number of RUN iterations.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start_i  input  1  divide request from EX. Held high by EX until ready_o is seen.
annul_i  input  1  cancel the in-flight divide (flush/exception).
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled with operands.
opdata1_i  input  DATA_WIDTH  dividend.
opdata2_i  input  DATA_WIDTH  divisor.
result_o  output  2*DATA_WIDTH  {remainder, quotient}: HI = [2W-1:W], LO = [W-1:0]. Registered.
ready_o  output  1  result valid. Registered.
stall_o  output  1  pipeline stall request. Combinational: start_i & ~ready_o.

Behaviour:
- Reset:
  - On rst = 1 at a clock edge: state = IDLE, counter = 0, working register = 0, result_o = 0, ready_o = 0.
  - Reset takes effect in any state, including mid-RUN.
- States: IDLE, BYZERO, RUN, DONE.
- IDLE:
  - If start_i = 1 and annul_i = 0: latch signed_div_i and the operand signs.
  - If the divisor is 0, go to BYZERO.
  - Otherwise load the working register and go to RUN with counter = 0:
    - |dividend| goes into the low half of the working register; the upper part is 0.
    - The divisor magnitude is stored.
    - Magnitude = two's-complement negation when signed and MSB = 1; else the raw value.
  - start_i with annul_i = 1 in IDLE is ignored.
- RUN:
  - Each edge with counter < DATA_WIDTH does one restoring step:
    - Shift the working register left by 1.
    - Compare the upper W+1 bits against the divisor magnitude.
    - If greater or equal, subtract and set quotient bit 1; else quotient bit 0.
    - counter += 1.
  - At the edge where counter == DATA_WIDTH:
    - Sign-correct: negate the quotient if signed and the operand signs differ; negate the remainder if signed and the dividend was negative.
    - Load result_o, set ready_o = 1, go to DONE.
- BYZERO: next edge sets result_o = 0, ready_o = 1, and goes to DONE.
- DONE:
  - While start_i = 1, hold: result_o and ready_o stay stable.
  - When start_i = 0: next edge goes to IDLE with ready_o = 0 and result_o = 0.
- annul_i:
  - In RUN or BYZERO with annul_i = 1: next edge goes to IDLE with ready_o = 0, result_o = 0, counter = 0. No result is produced.
  - annul_i in DONE behaves as start_i = 0 (return to IDLE).
- Latency:
  - The start edge is E0. Iterations run on E1..E32. Finalize happens on E33, so ready_o is high in the cycle after E33.
  - Divide-by-zero: ready_o is high after E1.
- Operand capture: operand and sign inputs are sampled only in IDLE. Later changes on the inputs do not affect an in-flight divide.
- Wrap/overflow: signed MIN_INT / -1 yields quotient 0x80000000 and remainder 0 (natural wrap). No trap.
- Back-to-back: a new divide is accepted only from IDLE. DONE must drop to IDLE first, so there is at least 1 idle cycle between results.
- stall_o rises in the same cycle as start_i. It falls in the cycle ready_o is 1.

Test Plan:
1. Unsigned 100 / 7, start held: stall_o = 1 from the start cycle; ready_o rises after edge E33; result_o = {0x00000002, 0x0000000E}. Drop start: ready_o = 0 and result_o = 0 one edge later.
2. Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat as unsigned: quotient 0x7FFFFFFC, remainder 0x00000001.
3. Divisor 0 (both signed modes): ready_o after E1; result_o = 0. Then signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
4. Start 1000 / 3, assert annul_i for one cycle at E10: state returns to IDLE and ready_o never rises. Immediately start 9 / 3: quotient 3, remainder 0 after 33 edges.
5. Assert rst at E15 of a running divide: all outputs 0 on the next edge and state is IDLE. A subsequent start completes with full 33-edge latency.
6. Hold start_i 5 cycles in DONE while toggling opdata1_i/opdata2_i: result_o is unchanged and ready_o stays 1 throughout.
